i_ap_sub_accum: RTL and testbench
=================================

I_AP_SUB_ACCUM -- requirements
Module: i_ap_sub_accum

Interface
REQ-001 The module SHALL have parameter bitlength, default 16, giving the data word width (two's complement).
REQ-002 The module SHALL have parameter Inf, default 16'b0111_1111_1111_1111, as the positive saturation bound; the negative bound SHALL be -Inf.
REQ-003 The module SHALL have parameter cntlength, default 8, giving the sample-count width.
REQ-004 The module SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  begin a run (sampled only in IDLE)
- n_samples  input  cntlength  number of (pos,neg) pairs in the run, latched on start
- in_valid  input  1  pos/neg pair valid
- in_ready  output  1  module accepts a pair
- pos  input signed  bitlength  positive-phase term
- neg  input signed  bitlength  negative-phase term
- out_valid  output  1  acc_out valid
- out_ready  input  1  consumer accepts the result
- acc_out  output signed  bitlength  saturated sum of (pos - neg)
- sat_flag  output  1  sticky flag: saturation occurred this run

Function
REQ-005 The FSM SHALL have the states IDLE, ACCUM and DONE.
REQ-006 In IDLE with start=1, the module SHALL latch n_samples, clear the accumulator, count and sat_flag, and enter ACCUM; if n_samples==0 it SHALL enter DONE instead.
REQ-007 start SHALL be ignored in ACCUM and DONE.
REQ-008 in_ready SHALL be 1 only in ACCUM; a pair is accepted on any cycle with in_valid & in_ready.
REQ-009 For each accepted pair: diff = pos - neg at bitlength+1 bits, clamped to [-Inf, Inf]; acc = acc + diff at bitlength+1 bits, clamped to [-Inf, Inf].
REQ-010 Either clamp firing SHALL set sat_flag, which then holds until the next start or reset.
REQ-011 The count SHALL increment per accepted pair; on acceptance of pair number n_samples, the module SHALL leave ACCUM (no further in_ready).
REQ-012 Without the pipeline option, DONE and out_valid=1 SHALL begin the cycle after the final acceptance.
REQ-013 In DONE, out_valid=1 and acc_out/sat_flag SHALL stay stable until out_valid & out_ready; the module then returns to IDLE with out_valid=0 on the next cycle.
REQ-014 acc_out SHALL show the running accumulator at all times; it is valid only while out_valid=1.
REQ-015 in_valid=0 cycles in ACCUM SHALL stall without changing state.

Reset
REQ-016 While rst=1, regardless of clk: state=IDLE, in_ready=0, out_valid=0, acc_out=0, sat_flag=0, count=0, pipeline register cleared.
REQ-017 Reset asserted mid-run SHALL abandon the run; no partial result SHALL be presented after reset.

Configuration
REQ-018 Macro I_AP_SUB_ACCUM_PIPE_EN, when defined, SHALL insert a register between the diff clamp and the accumulate stage:
- diff of the pair accepted in cycle t is accumulated in cycle t+1
- DONE/out_valid begins two cycles after the final acceptance
- in_ready remains 1 through the final acceptance, then 0
- sat_flag from the diff clamp is registered along with diff
REQ-019 When the macro is undefined, diff and accumulate SHALL occur in the acceptance cycle, with the latency given in REQ-012.

Verification
REQ-020 n_samples=3, pairs (10,1),(20,2),(30,3) -> acc_out=54, sat_flag=0, out_valid 1 (or 2 with PIPE_EN) cycle(s) after the third acceptance.
REQ-021 n_samples=1, pos=32767, neg=-32768 -> diff clamped to 32767, acc_out=32767, sat_flag=1.
REQ-022 n_samples=2, pairs (30000,0),(30000,0) -> acc_out=32767, sat_flag=1; n_samples=1, pair (-32768,32767) -> acc_out=-32767 (16'h8001), sat_flag=1.
REQ-023 start with n_samples=0 -> out_valid next cycle, acc_out=0, in_ready never 1; out_ready held 0 for 5 cycles -> out_valid and acc_out stay stable.
REQ-024 n_samples=4, rst pulsed after 2 acceptances -> immediate IDLE, all outputs 0; a new start with n_samples=1 and pair (5,7) -> acc_out=-2, sat_flag=0.
REQ-025 in_valid toggling 1,0,0,1 during ACCUM with start pulsed mid-run -> only valid-cycle pairs counted, start ignored, result equals the sum over the accepted pairs.

Source files
------------

// File: rtl/i_ap_sub_accum_if.sv
// Handshake bundle for i_ap_sub_accum: run control, (pos,neg) input stream and result channel.
interface i_ap_sub_accum_if #(
    parameter int bitlength = 16,
    parameter int cntlength = 8
);
    logic                        start;
    logic [cntlength-1:0]        n_samples;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [bitlength-1:0] pos;
    logic signed [bitlength-1:0] neg;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [bitlength-1:0] acc_out;
    logic                        sat_flag;

    modport master (
        output start, n_samples, in_valid, pos, neg, out_ready,
        input  in_ready, out_valid, acc_out, sat_flag
    );

    modport slave (
        input  start, n_samples, in_valid, pos, neg, out_ready,
        output in_ready, out_valid, acc_out, sat_flag
    );
endinterface

// File: rtl/i_ap_sub_accum.sv
// Saturating accumulator of (pos - neg) over a run of n_samples pairs.
// Define I_AP_SUB_ACCUM_PIPE_EN to register the clamped difference before accumulation.
module i_ap_sub_accum #(
    parameter int                          bitlength = 16,
    parameter logic signed [bitlength-1:0] Inf       = 16'b0111_1111_1111_1111,
    parameter int                          cntlength = 8
) (
    input  logic              clk,
    input  logic              rst,
    i_ap_sub_accum_if.slave   acc_if
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic signed [bitlength:0] POS_B = $signed({Inf[bitlength-1], Inf});
    localparam logic signed [bitlength:0] NEG_B = -POS_B;

    state_t                      state_q, state_d;
    logic [cntlength-1:0]        n_q, n_d;
    logic [cntlength-1:0]        cnt_q, cnt_d;
    logic signed [bitlength-1:0] acc_q, acc_d;
    logic                        sat_q, sat_d;

    logic                        accept;
    logic                        in_ready_w;
    logic                        out_valid_w;
    logic signed [bitlength:0]   diff_w;
    logic signed [bitlength-1:0] diff_c;
    logic                        diff_sat;
    logic signed [bitlength-1:0] add_op;
    logic                        add_en;
    logic                        add_sat;
    logic signed [bitlength:0]   sum_w;
    logic signed [bitlength-1:0] sum_c;
    logic                        sum_sat;

    // Both operands are widened by one bit so the raw result never wraps before clamping.
    always_comb begin
        diff_w   = {acc_if.pos[bitlength-1], acc_if.pos} - {acc_if.neg[bitlength-1], acc_if.neg};
        diff_sat = 1'b0;
        diff_c   = diff_w[bitlength-1:0];
        if (diff_w > POS_B) begin
            diff_c   = POS_B[bitlength-1:0];
            diff_sat = 1'b1;
        end else if (diff_w < NEG_B) begin
            diff_c   = NEG_B[bitlength-1:0];
            diff_sat = 1'b1;
        end
    end

`ifdef I_AP_SUB_ACCUM_PIPE_EN
    logic signed [bitlength-1:0] pdiff_q, pdiff_d;
    logic                        psat_q, psat_d;
    logic                        pvalid_q, pvalid_d;

    always_comb begin
        pdiff_d  = pdiff_q;
        psat_d   = psat_q;
        pvalid_d = accept;
        if (accept) begin
            pdiff_d = diff_c;
            psat_d  = diff_sat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pdiff_q  <= '0;
            psat_q   <= 1'b0;
            pvalid_q <= 1'b0;
        end else begin
            pdiff_q  <= pdiff_d;
            psat_q   <= psat_d;
            pvalid_q <= pvalid_d;
        end
    end

    assign add_op      = pdiff_q;
    assign add_en      = pvalid_q;
    assign add_sat     = psat_q;
    // The last difference is still in flight during the first DONE cycle.
    assign out_valid_w = (state_q == DONE) && !pvalid_q;
`else
    assign add_op      = diff_c;
    assign add_en      = accept;
    assign add_sat     = diff_sat;
    assign out_valid_w = (state_q == DONE);
`endif

    assign in_ready_w = (state_q == ACCUM);
    assign accept     = acc_if.in_valid && in_ready_w;

    always_comb begin
        sum_w   = {acc_q[bitlength-1], acc_q} + {add_op[bitlength-1], add_op};
        sum_sat = 1'b0;
        sum_c   = sum_w[bitlength-1:0];
        if (sum_w > POS_B) begin
            sum_c   = POS_B[bitlength-1:0];
            sum_sat = 1'b1;
        end else if (sum_w < NEG_B) begin
            sum_c   = NEG_B[bitlength-1:0];
            sum_sat = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sat_d   = sat_q;

        if (add_en) begin
            acc_d = sum_c;
            sat_d = sat_q | add_sat | sum_sat;
        end

        case (state_q)
            IDLE: begin
                if (acc_if.start) begin
                    n_d     = acc_if.n_samples;
                    cnt_d   = '0;
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    state_d = (acc_if.n_samples == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_q + cntlength'(1);
                    if (cnt_q + cntlength'(1) == n_q) state_d = DONE;
                end
            end
            DONE: begin
                if (out_valid_w && acc_if.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
        end
    end

    assign acc_if.in_ready  = in_ready_w;
    assign acc_if.out_valid = out_valid_w;
    assign acc_if.acc_out   = acc_q;
    assign acc_if.sat_flag  = sat_q;
endmodule

// File: tb/tb_i_ap_sub_accum.sv
// Self-checking bench for i_ap_sub_accum: directed vector table, hand-written reset/stall
// sequences and randomized runs against an integer reference model.
module tb_i_ap_sub_accum;
    localparam int INF = 32767;
`ifdef I_AP_SUB_ACCUM_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i_ap_sub_accum_if #(.bitlength(16), .cntlength(8)) bus ();
    i_ap_sub_accum dut (.clk(clk), .rst(rst), .acc_if(bus));

    int n_checks = 0;
    int n_fail   = 0;
    int pa [0:255];
    int na [0:255];

    typedef struct {
        int n;
        int p [4];
        int q [4];
        int hold;
        int exp_acc;
        int exp_sat;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic with explicit clamps.
    task automatic model(input int n, output int acc, output int sat);
        int d;
        acc = 0;
        sat = 0;
        for (int i = 0; i < n; i++) begin
            d = pa[i] - na[i];
            if (d > INF) begin d = INF; sat = 1; end
            if (d < -INF) begin d = -INF; sat = 1; end
            acc = acc + d;
            if (acc > INF) begin acc = INF; sat = 1; end
            if (acc < -INF) begin acc = -INF; sat = 1; end
        end
    endtask

    // mode 0: in_valid always 1; mode 1: random gaps; mode 2: valid pattern 1,0,0 with start pulsed
    task automatic run(input string tag, input int n, input int mode, input int hold,
                       input int exp_acc, input int exp_sat);
        int idx, cyc, lat;
        bit rdy, v;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.n_samples = 8'(n);
        @(negedge clk);
        bus.start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 300) begin
            rdy = bus.in_ready;
            chk({tag, " in_ready_accum"}, int'(rdy), 1);
            case (mode)
                0:       v = 1'b1;
                1:       v = ($urandom_range(0, 2) != 0);
                default: v = (cyc % 3 == 0);
            endcase
            bus.in_valid  = v;
            bus.pos       = v ? 16'(pa[idx]) : 16'($urandom);
            bus.neg       = v ? 16'(na[idx]) : 16'($urandom);
            bus.start     = (mode == 2) ? (cyc % 3 == 1) : ((mode == 1) && $urandom_range(0, 3) == 0);
            bus.n_samples = 8'($urandom);
            @(negedge clk);
            cyc++;
            if (v && rdy) idx++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        if (idx < n) chk({tag, " feed_timeout"}, idx, n);
        chk({tag, " in_ready_after_last"}, int'(bus.in_ready), 0);
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, (n == 0) ? 1 : LAT);
        chk({tag, " acc_out"}, int'(bus.acc_out), exp_acc);
        chk({tag, " sat_flag"}, int'(bus.sat_flag), exp_sat);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, " hold_valid"}, int'(bus.out_valid), 1);
            chk({tag, " hold_acc"}, int'(bus.acc_out), exp_acc);
            chk({tag, " hold_sat"}, int'(bus.sat_flag), exp_sat);
            chk({tag, " hold_in_ready"}, int'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, " valid_dropped"}, int'(bus.out_valid), 0);
        $display("run %s n=%0d acc_out=%0d sat=%0d latency=%0d", tag, n, int'(bus.acc_out), bus.sat_flag, lat);
    endtask

    vec_t vecs [10];
    int   m_acc, m_sat, rn;

    initial begin
        bus.start = 1'b0; bus.n_samples = '0; bus.in_valid = 1'b0;
        bus.pos = '0; bus.neg = '0; bus.out_ready = 1'b0;

        vecs[0] = '{3, '{10, 20, 30, 0}, '{1, 2, 3, 0}, 0, 54, 0};
        vecs[1] = '{1, '{32767, 0, 0, 0}, '{-32768, 0, 0, 0}, 1, 32767, 1};
        vecs[2] = '{2, '{30000, 30000, 0, 0}, '{0, 0, 0, 0}, 0, 32767, 1};
        vecs[3] = '{1, '{-32768, 0, 0, 0}, '{32767, 0, 0, 0}, 0, -32767, 1};
        vecs[4] = '{0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 5, 0, 0};
        vecs[5] = '{2, '{-30000, -30000, 0, 0}, '{0, 0, 0, 0}, 0, -32767, 1};
        vecs[6] = '{2, '{32767, -100, 0, 0}, '{-32768, 0, 0, 0}, 0, 32667, 1};
        vecs[7] = '{1, '{32767, 0, 0, 0}, '{0, 0, 0, 0}, 0, 32767, 0};
        vecs[8] = '{1, '{-1, 0, 0, 0}, '{32767, 0, 0, 0}, 0, -32767, 1};
        vecs[9] = '{4, '{100, -50, 7, -3}, '{0, 25, -7, 4}, 2, 32, 0};

        // Reset state, no clock edge required for it to be visible.
        #3;
        chk("rst in_ready", int'(bus.in_ready), 0);
        chk("rst out_valid", int'(bus.out_valid), 0);
        chk("rst acc_out", int'(bus.acc_out), 0);
        chk("rst sat_flag", int'(bus.sat_flag), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 4; k++) begin
                pa[k] = vecs[i].p[k];
                na[k] = vecs[i].q[k];
            end
            run($sformatf("vec%0d", i), vecs[i].n, 0, vecs[i].hold, vecs[i].exp_acc, vecs[i].exp_sat);
        end

        // Stall pattern 1,0,0,1 with start pulsed inside the gaps.
        pa[0] = 1234; na[0] = -66; pa[1] = -200; na[1] = 300;
        run("stall", 2, 2, 1, 800, 0);

        // Reset mid-run after two acceptances abandons the run.
        @(negedge clk);
        bus.start = 1'b1; bus.n_samples = 8'd4;
        @(negedge clk);
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.pos = 16'sd30000; bus.neg = -16'sd30000;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst in_ready", int'(bus.in_ready), 0);
        chk("midrst out_valid", int'(bus.out_valid), 0);
        chk("midrst acc_out", int'(bus.acc_out), 0);
        chk("midrst sat_flag", int'(bus.sat_flag), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("postrst out_valid", int'(bus.out_valid), 0);
        chk("postrst in_ready", int'(bus.in_ready), 0);
        pa[0] = 5; na[0] = 7;
        run("after_rst", 1, 0, 0, -2, 0);

        for (int r = 0; r < 25; r++) begin
            rn = $urandom_range(1, 12);
            for (int k = 0; k < rn; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    pa[k] = $urandom_range(0, 1) ? 32767 : -32768;
                    na[k] = $urandom_range(0, 1) ? 32767 : -32768;
                end else begin
                    pa[k] = int'($signed(16'($urandom)));
                    na[k] = int'($signed(16'($urandom)));
                end
            end
            model(rn, m_acc, m_sat);
            run($sformatf("rand%0d", r), rn, 1, $urandom_range(0, 3), m_acc, m_sat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
